// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg: segment codes, digit count and converter state encodings for the display scanner
package seg_scan_ctrl_pkg;
  localparam int unsigned NUM_DIGITS = 6;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [9:0][7:0] SEG_TBL = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                         SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} cvt_state_e;

  // Active-low code for one BCD digit, dp off; non-BCD nibbles read as blank.
  function automatic logic [7:0] seg_code(input logic [3:0] n);
    return n > 4'd9 ? SEG_BLANK : SEG_TBL[n];
  endfunction
endpackage

// File: rtl/seg_scan_ctrl_bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble converter, 20-bit binary to six BCD digits with saturation
module bin2bcd_seq
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned MAX_VAL = 999_999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [19:0] bin,
  output logic        busy,
  output logic        load,
  output logic        done,
  output logic [23:0] bcd
);
  localparam logic [19:0] MAX_V = 20'(MAX_VAL);

  cvt_state_e  state_q, state_d;
  logic [19:0] bin_q, bin_d;
  logic [23:0] bcd_q, bcd_d, adj;
  logic [4:0]  cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    adj     = bcd_q;
    for (int k = 0; k < 6; k++)
      adj[k*4 +: 4] = bcd_q[k*4 +: 4] >= 4'd5 ? bcd_q[k*4 +: 4] + 4'd3 : bcd_q[k*4 +: 4];
    case (state_q)
      ST_IDLE: state_d = start ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        bin_d   = bin > MAX_V ? MAX_V : bin;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        bcd_d   = {adj[22:0], bin_q[19]};
        bin_d   = {bin_q[18:0], 1'b0};
        cnt_d   = cnt_q + 5'd1;
        state_d = cnt_q == 5'd19 ? ST_DONE : ST_SHIFT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end

  assign busy = state_q != ST_IDLE;
  assign load = state_q == ST_LOAD;
  assign done = state_q == ST_DONE;
  assign bcd  = bcd_q;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 6-digit common-anode 7-segment scanner with BCD conversion,
// leading-zero blanking, decimal points and minus sign
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50_000,
  parameter int unsigned MAX_VAL  = 999_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        sign,
  input  logic        en,
  output logic [5:0]  seg_sel,
  output logic [7:0]  seg_led
);
  localparam int CW = SCAN_DIV > 2 ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [5:0]    pt_snap_q, pt_snap_d, disp_pt_q, disp_pt_d;
  logic          sign_snap_q, sign_snap_d, disp_sign_q, disp_sign_d;
  logic [23:0]   disp_bcd_q, disp_bcd_d, bcd;
  logic          valid_q, valid_d;
  logic [5:0]    sel_q, sel_d;
  logic [7:0]    led_q, led_d, code;
  logic [2:0]    msd, pmax, eff;
  logic [3:0]    dig;
  logic          busy, load, done, term;

  bin2bcd_seq #(.MAX_VAL(MAX_VAL)) u_cvt (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .start (!busy),
    .bin   (data),
    .busy  (busy),
    .load  (load),
    .done  (done),
    .bcd   (bcd)
  );

  always_comb begin
    term        = cnt_q == CW'(SCAN_DIV - 1);
    cnt_d       = term ? '0 : cnt_q + 1'b1;
    idx_d       = term ? (idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1) : idx_q;
    pt_snap_d   = load ? point : pt_snap_q;
    sign_snap_d = load ? sign : sign_snap_q;
    // Value, points and sign move to the display together so a frame never mixes conversions.
    disp_bcd_d  = done ? bcd : disp_bcd_q;
    disp_pt_d   = done ? pt_snap_q : disp_pt_q;
    disp_sign_d = done ? sign_snap_q : disp_sign_q;
    valid_d     = done | valid_q;
    msd         = '0;
    pmax        = '0;
    for (int k = 1; k < 6; k++) begin
      if (disp_bcd_q[k*4 +: 4] != 4'd0) msd = 3'(k);
      if (disp_pt_q[k]) pmax = 3'(k);
    end
    eff  = msd > pmax ? msd : pmax;
    dig  = disp_bcd_q[{idx_q, 2'b00} +: 4];
    code = idx_q <= eff ? seg_code(dig) & {~disp_pt_q[idx_q], 7'h7F} :
           disp_sign_q && idx_q == eff + 3'd1 ? SEG_MINUS : SEG_BLANK;
    sel_d = en && valid_q ? ~(6'b1 << idx_q) : 6'h3F;
    led_d = en && valid_q ? code : SEG_BLANK;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pt_snap_q   <= '0;
      sign_snap_q <= 1'b0;
      disp_bcd_q  <= '0;
      disp_pt_q   <= '0;
      disp_sign_q <= 1'b0;
      valid_q     <= 1'b0;
      sel_q       <= 6'h3F;
      led_q       <= SEG_BLANK;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pt_snap_q   <= pt_snap_d;
      sign_snap_q <= sign_snap_d;
      disp_bcd_q  <= disp_bcd_d;
      disp_pt_q   <= disp_pt_d;
      disp_sign_q <= disp_sign_d;
      valid_q     <= valid_d;
      sel_q       <= sel_d;
      led_q       <= led_d;
    end

  assign seg_sel = sel_q;
  assign seg_led = led_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of scan order, decode, blanking, sign, saturation and atomic update
module tb_seg_scan_ctrl;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [19:0] data = '0;
  logic [5:0]  point = '0;
  logic        sign = 1'b0;
  logic        en = 1'b0;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_led;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc;

  seg_scan_ctrl #(.SCAN_DIV(4), .MAX_VAL(999_999)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .data      (data),
    .point     (point),
    .sign      (sign),
    .en        (en),
    .seg_sel   (seg_sel),
    .seg_led   (seg_led)
  );

  always #5 sys_clk = ~sys_clk;

  // Edges since the last reset release; the converter period is 23 of these.
  always @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // exp holds digit k at exp[k*8 +: 8]; checks one full scan from digit 0 plus the wrap.
  task automatic frame(input string tag, input logic [47:0] exp);
    logic [5:0] es;
    for (int n = 0; n < 40 && seg_sel !== 6'h3E; n++) @(negedge sys_clk);
    for (int k = 0; k < 6; k++) begin
      es = ~(6'b1 << k);
      chk($sformatf("%s_sel%0d", tag, k), 32'(seg_sel), 32'(es));
      chk($sformatf("%s_led%0d", tag, k), 32'(seg_led), 32'(exp[k*8 +: 8]));
      repeat (4) @(negedge sys_clk);
    end
    chk($sformatf("%s_wrap", tag), 32'(seg_sel), 32'h3E);
  endtask

  task automatic show(input logic [19:0] d, input logic [5:0] p, input logic s);
    data  = d;
    point = p;
    sign  = s;
    repeat (60) @(negedge sys_clk);
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge sys_clk);
      chk("dis_sel", 32'(seg_sel), 32'h3F);
      chk("dis_led", 32'(seg_led), 32'hFF);
    end

    en = 1'b1;
    show(20'd123456, 6'h00, 1'b0);
    frame("v123456", {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});

    repeat (2) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_sel", 32'(seg_sel), 32'h3F);
    chk("rst_led", 32'(seg_led), 32'hFF);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge sys_clk);
      if (i % 5 == 4) begin
        chk("post_rst_sel", 32'(seg_sel), 32'h3F);
        chk("post_rst_led", 32'(seg_led), 32'hFF);
      end
    end

    show(20'd42, 6'h00, 1'b1);
    frame("v42neg", {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h99, 8'hA4});
    show(20'd5, 6'b000100, 1'b0);
    frame("v5dp", {8'hFF, 8'hFF, 8'hFF, 8'h40, 8'hC0, 8'h92});
    show(20'd5, 6'b000100, 1'b1);
    frame("v5dpneg", {8'hFF, 8'hFF, 8'hBF, 8'h40, 8'hC0, 8'h92});
    show(20'd1_048_575, 6'h00, 1'b0);
    frame("sat", {6{8'h90}});
    show(20'd0, 6'h00, 1'b0);
    frame("zero", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});
    show(20'd7, 6'b100000, 1'b1);
    frame("dp5neg", {8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hF8});

    en = 1'b0;
    @(negedge sys_clk);
    chk("en_off_sel", 32'(seg_sel), 32'h3F);
    chk("en_off_led", 32'(seg_led), 32'hFF);
    en = 1'b1;

    show(20'd111111, 6'h00, 1'b0);
    frame("v111111", {6{8'hF9}});
    for (int n = 0; n < 30 && cyc % 23 != 12; n++) @(negedge sys_clk);
    chk("shift_phase", 32'(cyc % 23), 32'd12);
    data = 20'd222222;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      chk($sformatf("hold%0d", i), 32'(seg_led), 32'hF9);
    end
    repeat (15) @(negedge sys_clk);
    frame("v222222", {6{8'hA4}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
